// File: rtl/msk_aes_out_serializer_pkg.sv
// Shared constants and state encoding for the masked AES output serializer.
// Shares are only ever moved here; nothing in this slice combines them.
package msk_aes_out_serializer_pkg;

    localparam int DEF_D          = 2;
    localparam int DEF_BLOCK_BITS = 128;
    localparam int DEF_WORD_BITS  = 32;
    localparam int DEF_NBEATS     = DEF_BLOCK_BITS / DEF_WORD_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Beat counter width, kept at least one bit for single-beat configurations.
    function automatic int cnt_width(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/msk_aes_out_serializer_if.sv
// Core-side block handshake plus downstream beat handshake, both in shbus encoding.
interface msk_aes_out_serializer_if #(
    parameter int d          = 2,
    parameter int BLOCK_BITS = 128,
    parameter int WORD_BITS  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BLOCK_BITS*d-1:0]   sh_data_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_BITS*d-1:0]    sh_data_out;
    logic                      out_last;
    logic                      busy;

    modport slave (
        input  in_valid, sh_data_in, out_ready,
        output in_ready, out_valid, sh_data_out, out_last, busy
    );

    modport master (
        output in_valid, sh_data_in, out_ready,
        input  in_ready, out_valid, sh_data_out, out_last, busy
    );
endinterface

// File: rtl/msk_aes_out_serializer.sv
// Holds one shared ciphertext block and streams it out as NBEATS shbus words.
// The word mux select is the public beat counter only, so shares never mix.
module msk_aes_out_serializer
    import msk_aes_out_serializer_pkg::*;
#(
    parameter int d          = DEF_D,
    parameter int BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    msk_aes_out_serializer_if.slave  bus
);

    localparam int NBEATS = BLOCK_BITS / WORD_BITS;
    localparam int CNT_W  = cnt_width(NBEATS);
    localparam int BEAT_W = WORD_BITS * d;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLOCK_BITS*d-1:0] blk_q;
    logic                    last_beat;
    logic                    in_ready;
    logic                    load;

    // in_ready depends on out_ready but never on in_valid, so the core sees no loop.
    assign last_beat = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign in_ready  = (state_q == IDLE) || (last_beat && bus.out_ready);
    assign load      = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = load ? SEND : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data needs no reset: a dropped block is simply never presented again.
    always_ff @(posedge clk) begin
        if (load) blk_q <= bus.sh_data_in;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == SEND);
    assign bus.out_last    = last_beat;
    assign bus.busy        = (state_q == SEND);
    assign bus.sh_data_out = blk_q[cnt_q*BEAT_W +: BEAT_W];

endmodule
